// File: rtl/mimc_pkg.sv
// Shared definitions for the BN254 MiMC datapath.
//   N_BITS  : field word width (products are 2*N_BITS wide)
//   BN254_R : BN254 scalar-field modulus
//   state_t : control states of the sequential modular reducer
package mimc_pkg;

    localparam int unsigned N_BITS = 256;

    localparam logic [N_BITS-1:0] BN254_R =
        256'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : mimc_pkg

// File: rtl/mod_red_step.sv
// One radix-2 restoring reduction step (purely combinational).
// Shifts the next product bit into the running remainder and subtracts the
// modulus once if the shifted value is not below it.
// Ports:
//   rem_in  in  N_BITS   current remainder, always < MODULUS
//   bit_in  in  1        next product bit, MSB first
//   rem_out out N_BITS   ({rem_in, bit_in}) mod MODULUS
module mod_red_step
    import mimc_pkg::*;
#(
    parameter int unsigned       W       = N_BITS,
    parameter logic [W-1:0]      MODULUS = BN254_R
) (
    input  logic [W-1:0] rem_in,
    input  logic         bit_in,
    output logic [W-1:0] rem_out
);

    logic [W:0]   t;
    logic [W+1:0] diff;
    logic         borrow;

    assign t      = {rem_in, bit_in};
    // Trial subtract one bit wider than t so the top bit is the borrow.
    assign diff   = {1'b0, t} - {2'b00, MODULUS};
    assign borrow = diff[W+1];

    // rem_in < MODULUS makes t < 2*MODULUS, so one conditional subtract
    // always lands in [0, MODULUS) and the dropped upper bits are zero.
    assign rem_out = W'(borrow ? {1'b0, t} : diff);

endmodule : mod_red_step

// File: rtl/mod_reduce_bn254_seq.sv
// Sequential BN254 modular reducer: result = product mod BN254_R.
// Restoring reduction consuming one product bit per clock, MSB first;
// the result appears 2*N_BITS cycles after the input handshake.
// Ports:
//   clk       in   1         rising-edge clock
//   rst       in   1         synchronous active-high reset
//   in_valid  in   1         product valid
//   in_ready  out  1         high only in IDLE
//   product   in   2*N_BITS  unreduced product
//   out_valid out  1         result valid, held until out_ready
//   out_ready in   1         downstream accepts result
//   result    out  N_BITS    canonical residue; holds its value until the next completion
//   busy      out  1         high in RUN or DONE
module mod_reduce_bn254_seq
    import mimc_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2*N_BITS-1:0] product,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N_BITS-1:0]   result,
    output logic                busy
);

    localparam logic [8:0] LAST_CNT = 9'(2*N_BITS - 1);

    state_t              state, state_next;
    logic [2*N_BITS-1:0] shreg;
    logic [N_BITS-1:0]   rem;
    logic [N_BITS-1:0]   rem_next;
    logic [8:0]          cnt;

    mod_red_step #(
        .W       (N_BITS),
        .MODULUS (BN254_R)
    ) u_step (
        .rem_in  (rem),
        .bit_in  (shreg[2*N_BITS-1]),
        .rem_out (rem_next)
    );

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic.
    // NOTE: default assignment first so no path leaves state_next unassigned
    // (which would infer a latch).
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (in_valid)          state_next = RUN;
            RUN:  if (cnt == LAST_CNT)   state_next = DONE;
            DONE: if (out_ready)         state_next = IDLE;
            default:                     state_next = IDLE;
        endcase
    end

    // Output decode.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
    end

    // Datapath: shift register, remainder, bit counter and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg  <= '0;
            rem    <= '0;
            cnt    <= '0;
            result <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        shreg <= product;
                        rem   <= '0;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    rem   <= rem_next;
                    shreg <= shreg << 1;
                    cnt   <= cnt + 9'd1;
                    if (cnt == LAST_CNT) result <= rem_next;
                end
                default: ;
            endcase
        end
    end

endmodule : mod_reduce_bn254_seq

// File: tb/tb_mod_reduce_bn254_seq.sv
// Self-checking bench for mod_reduce_bn254_seq. The reference residue is
// computed with plain wide-integer modulo on the full 512-bit product.
module tb_mod_reduce_bn254_seq;
    import mimc_pkg::*;

    localparam logic [511:0] P512 = {256'b0, BN254_R};
    localparam int TIMEOUT = 700;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [511:0]   product = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [255:0]   result;
    logic           busy;

    int errors = 0;
    int checks = 0;

    mod_reduce_bn254_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .product   (product),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] ref_mod(input logic [511:0] x);
        logic [511:0] r;
        r = x % P512;
        return r[255:0];
    endfunction

    function automatic logic [511:0] rand512();
        logic [511:0] v = '0;
        for (int k = 0; k < 16; k++) v = {v[479:0], 32'($urandom)};
        return v;
    endfunction

    // Step to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a product, wait for the result, hold it for 'hold' cycles,
    // then complete the output handshake. No comparisons here.
    task automatic do_transaction(input logic [511:0] p, input int hold,
                                  output logic [255:0] res, output int lat,
                                  output bit ok);
        int w = 0;
        ok  = 1'b1;
        lat = 0;
        res = '0;
        while (!in_ready && w < TIMEOUT) begin tick(); w++; end
        if (!in_ready) begin ok = 1'b0; return; end
        in_valid = 1'b1;
        product  = p;
        tick();                      // accepting edge
        in_valid = 1'b0;
        while (!out_valid && lat < TIMEOUT) begin tick(); lat++; end
        if (!out_valid) begin ok = 1'b0; return; end
        res = result;
        repeat (hold) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic check_res(input string name, input logic [511:0] p,
                             input logic [255:0] exp);
        logic [255:0] res;
        int lat;
        bit ok;
        do_transaction(p, 0, res, lat, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: timeout waiting for handshake", name);
        end else if (res !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, res, exp);
        end
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        in_valid = 1'b1;
        product  = '1;
        tick();
        tick();
        checks++;
        if ({in_ready, out_valid, busy} !== 3'b100 || result !== '0) begin
            errors++;
            $display("FAIL reset_state: in_ready/out_valid/busy=%b result=%h expected 100 and 0",
                     {in_ready, out_valid, busy}, result);
        end
        in_valid = 1'b0;
        rst      = 1'b0;
        tick();
    endtask

    task automatic test_zero_latency();
        logic [255:0] res;
        int lat;
        bit ok;
        do_transaction('0, 0, res, lat, ok);
        checks++;
        if (!ok || res !== '0) begin
            errors++;
            $display("FAIL zero_product: got %h ok=%0d expected 0", res, ok);
        end
        checks++;
        if (lat !== 512) begin
            errors++;
            $display("FAIL latency: got %0d cycles expected 512", lat);
        end
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_handshake: out_valid=%b in_ready=%b expected 0 1",
                     out_valid, in_ready);
        end
    endtask

    task automatic test_boundaries();
        logic [511:0] mm1;
        mm1 = P512 - 512'd1;
        check_res("mod_plus_5",     P512 + 512'd5,       256'd5);
        check_res("mod_exact",      P512,                256'd0);
        check_res("mod_m1_squared", mm1 * mm1,           256'd1);
        check_res("mod_sq_plus_7",  P512 * P512 + 512'd7, 256'd7);
        check_res("chain_a_b_m2",   (P512 - 512'd2) * (P512 - 512'd2), 256'd4);
        check_res("all_ones",       '1,                  ref_mod('1));
    endtask

    task automatic test_random(input int n);
        logic [511:0] p;
        logic [255:0] res;
        int lat;
        bit ok;
        for (int i = 0; i < n; i++) begin
            p = rand512();
            do_transaction(p, int'($urandom_range(0, 3)), res, lat, ok);
            checks++;
            if (!ok || res !== ref_mod(p)) begin
                errors++;
                $display("FAIL random[%0d]: got %h expected %h ok=%0d", i, res, ref_mod(p), ok);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [511:0] p;
        logic [255:0] exp;
        int w = 0;
        p   = rand512();
        exp = ref_mod(p);
        in_valid = 1'b1;
        product  = p;
        tick();
        in_valid = 1'b0;
        while (!out_valid && w < TIMEOUT) begin tick(); w++; end
        for (int c = 0; c < 10; c++) begin
            // Offer a different product every other cycle; it must be ignored.
            in_valid = c[0];
            product  = ~p;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1 || result !== exp) begin
                errors++;
                $display("FAIL backpressure[%0d]: ov=%b ir=%b busy=%b result=%h expected 1 0 1 %h",
                         c, out_valid, in_ready, busy, result, exp);
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || result !== exp) begin
            errors++;
            $display("FAIL after_release: ov=%b ir=%b busy=%b result=%h expected 0 1 0 %h",
                     out_valid, in_ready, busy, result, exp);
        end
    endtask

    task automatic test_reset_mid_run();
        in_valid = 1'b1;
        product  = rand512();
        tick();
        in_valid = 1'b0;
        repeat (100) tick();
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_run_busy: busy=%b in_ready=%b expected 1 0", busy, in_ready);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort: ir=%b ov=%b busy=%b result=%h expected 1 0 0 0",
                     in_ready, out_valid, busy, result);
        end
        check_res("after_abort_plus_3", P512 + 512'd3, 256'd3);
    endtask

    initial begin
        test_reset();
        test_zero_latency();
        test_boundaries();
        test_backpressure();
        test_reset_mid_run();
        test_random(120);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_mod_reduce_bn254_seq
